// File: rtl/ex_iter.sv
//-----------------------------------------------------------------------------
// ex_iter -- execute stage with single-cycle ALU and iterative divider
//
// Sits between ID/EX and EX/MEM. Logic, shift, add/sub and compare ops
// produce a registered result one cycle after acceptance. DIV/DIVU run a
// restoring shift-subtract divider (one bit per cycle) that writes the
// internal HI (remainder) and LO (quotient) registers; MFHI/MFLO read them.
// stall_o freezes upstream while a divide is running.
//
// Parameters:
//   WIDTH    datapath width (power of two, >= 8)
//   RADDR_W  register-file address width
//   SHW      shift-amount width, derived from WIDTH
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   valid_i, op_i     op presented this cycle and its opcode
//   a_i, b_i          operands (a_i also supplies the shift amount)
//   wd_i, wreg_i      destination register and write-enable request
//   flush_i           kill the op presented and any divide in flight
//   valid_o           one-cycle result pulse per op
//   wd_o, wreg_o      registered destination / write enable
//   wdata_o           result (held when no result is produced)
//   stall_o           upstream must hold its inputs
//   hi_o, lo_o        HI / LO registers
//
// Optional build macro EX_ITER_PERF_EN adds div_cnt_o (completed divides)
// and stall_cnt_o (stalled cycles), both 32-bit saturating.
//-----------------------------------------------------------------------------
module ex_iter #(
   parameter  int WIDTH   = 32,
   parameter  int RADDR_W = 5,
   localparam int SHW     = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [3:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [RADDR_W-1:0] wd_i,
   input  logic               wreg_i,
   input  logic               flush_i,
`ifdef EX_ITER_PERF_EN
   output logic [31:0]        div_cnt_o,
   output logic [31:0]        stall_cnt_o,
`endif
   output logic               valid_o,
   output logic [RADDR_W-1:0] wd_o,
   output logic               wreg_o,
   output logic [WIDTH-1:0]   wdata_o,
   output logic               stall_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);

   typedef enum logic [3:0] {
      OP_OR   = 4'd0,  OP_AND  = 4'd1,  OP_NOR  = 4'd2,  OP_XOR  = 4'd3,
      OP_SLL  = 4'd4,  OP_SRL  = 4'd5,  OP_SRA  = 4'd6,  OP_ADD  = 4'd7,
      OP_SUB  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU = 4'd10, OP_DIV  = 4'd11,
      OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_NOP  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   op_e              op;
   state_e           state, state_nxt;
   logic             op_is_div;
   logic             div_start;
   logic             div_zero;
   logic             single_acc;
   logic             last_step;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;

   // Divider working registers: partial remainder, dividend/quotient shift
   // register, divisor magnitude and the sign corrections to apply at the end.
   logic [SHW-1:0]     count;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_dvs;
   logic               neg_q;
   logic               neg_r;
   logic [RADDR_W-1:0] div_wd;

   logic               sgn_div;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               step_ge;
   logic [WIDTH-1:0]   step_rem;
   logic [WIDTH-1:0]   step_quo;
   logic [WIDTH-1:0]   fin_q;
   logic [WIDTH-1:0]   fin_r;

   assign op        = op_e'(op_i);
   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign shamt     = a_i[SHW-1:0];
   assign div_zero  = (b_i == '0);

   // A divide starts only from IDLE. In DONE the divide still on the inputs
   // is the one just completing (upstream held it), so it is not restarted.
   assign div_start = (state == S_IDLE) && valid_i && op_is_div && !flush_i;
   assign stall_o   = (state == S_RUN) || div_start;

   // Single-cycle ops are taken whenever the divider is not running.
   assign single_acc = valid_i && !op_is_div && !flush_i && (state != S_RUN);

   assign last_step = (state == S_RUN) && (count == SHW'(WIDTH - 1));

   // Operand magnitudes and sign flags for a signed divide.
   assign sgn_div = (op == OP_DIV);
   assign a_mag   = (sgn_div && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag   = (sgn_div && b_i[WIDTH-1]) ? -b_i : b_i;

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. Since rem < divisor, a non-negative
   // difference always fits in WIDTH bits, so diff[WIDTH] is a clean borrow.
   assign shifted  = {div_rem, div_quo[WIDTH-1]};
   assign diff     = shifted - {1'b0, div_dvs};
   assign step_ge  = !diff[WIDTH];
   assign step_rem = step_ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign step_quo = {div_quo[WIDTH-2:0], step_ge};

   // Quotient takes the XOR of the operand signs, remainder the dividend's.
   assign fin_q = neg_q ? -step_quo : step_quo;
   assign fin_r = neg_r ? -step_rem : step_rem;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_OR:   alu_res = a_i | b_i;
         OP_AND:  alu_res = a_i & b_i;
         OP_NOR:  alu_res = ~(a_i | b_i);
         OP_XOR:  alu_res = a_i ^ b_i;
         OP_SLL:  alu_res = b_i << shamt;
         OP_SRL:  alu_res = b_i >> shamt;
         OP_SRA:  alu_res = $signed(b_i) >>> shamt;
         OP_ADD:  alu_res = a_i + b_i;
         OP_SUB:  alu_res = a_i - b_i;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
         OP_MFHI: alu_res = hi_o;
         OP_MFLO: alu_res = lo_o;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values and the block order cannot change behaviour.
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: the default comes first so every path assigns state_nxt and
      // no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE: if (div_start) state_nxt = div_zero ? S_DONE : S_RUN;
         S_RUN: begin
            if (flush_i)        state_nxt = S_IDLE;
            else if (last_step) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Results are written on the edge that enters DONE, so they are visible
   // during the DONE cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         wreg_o  <= 1'b0;
         wd_o    <= '0;
         wdata_o <= '0;
         hi_o    <= '0;
         lo_o    <= '0;
         count   <= '0;
         div_rem <= '0;
         div_quo <= '0;
         div_dvs <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div_wd  <= '0;
      end else begin
         valid_o <= 1'b0;
         wreg_o  <= 1'b0;

         if (div_start) begin
            div_wd <= wd_i;
            if (div_zero) begin
               lo_o    <= '1;
               hi_o    <= a_i;
               valid_o <= 1'b1;
               wd_o    <= wd_i;
               wdata_o <= '1;
            end else begin
               count   <= '0;
               div_rem <= '0;
               div_quo <= a_mag;
               div_dvs <= b_mag;
               neg_q   <= sgn_div && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               neg_r   <= sgn_div && a_i[WIDTH-1];
            end
         end

         if (state == S_RUN && !flush_i) begin
            count   <= count + SHW'(1);
            div_rem <= step_rem;
            div_quo <= step_quo;
            if (last_step) begin
               lo_o    <= fin_q;
               hi_o    <= fin_r;
               valid_o <= 1'b1;
               wd_o    <= div_wd;
               wdata_o <= fin_q;
            end
         end

         if (single_acc) begin
            valid_o <= 1'b1;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i && (op != OP_NOP);
            wdata_o <= alu_res;
         end
      end
   end

`ifdef EX_ITER_PERF_EN
   logic div_done_evt;

   assign div_done_evt = (div_start && div_zero) || (last_step && !flush_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_o   <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (div_done_evt && div_cnt_o != '1) div_cnt_o <= div_cnt_o + 32'd1;
         if (stall_o && stall_cnt_o != '1)    stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
